// File: rtl/vram_write_scheduler.sv
// Buffers CPU-side VRAM writes and replays them into the GPU VRAM port,
// strictly in order, only while the video timing reports the vblank window.
module vram_write_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 16
) (
  input  logic                    gpu_clk,
  input  logic                    rst,
  input  logic                    i_writable,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [7:0]              i_req_data,
  input  logic [4:0]              i_req_sel,
  output logic [ADDR_WIDTH-1:0]   o_vram_address,
  output logic [7:0]              o_vram_data,
  output logic                    o_vram_we,
  output logic [4:0]              o_vram_sel,
  output logic [$clog2(DEPTH):0]  o_pending,
  output logic                    o_overflow,
  input  logic                    i_clr_overflow,
  output logic                    o_drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = ADDR_WIDTH + 13;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [EW-1:0]         r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_vram_address;
  logic [7:0]            r_vram_data;
  logic                  r_vram_we;
  logic [4:0]            r_vram_sel;
  logic                  r_overflow;
  logic                  r_drained;

  logic [PW-1:0]         w_pending;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_pending = r_wr_ptr - r_rd_ptr;
  assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push    = i_req_valid && !w_full;
  assign w_pop     = (r_state == S_DRAIN) && i_writable && !w_empty;
  assign w_last    = (w_pending == PW'(1)) && !w_push;

  assign o_req_ready    = !w_full;
  assign o_pending      = w_pending;
  assign o_overflow     = r_overflow;
  assign o_drained      = r_drained;
  assign o_vram_address = r_vram_address;
  assign o_vram_data    = r_vram_data;
  assign o_vram_we      = r_vram_we;
  assign o_vram_sel     = r_vram_sel;

  always_ff @(posedge gpu_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_req_addr, i_req_data, i_req_sel};
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      // Clearing wins over a simultaneous drop so software never misses the clear.
      if (i_clr_overflow)
        r_overflow <= 1'b0;
      else if (i_req_valid && w_full)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_vram_address <= '0;
      r_vram_data    <= '0;
      r_vram_we      <= 1'b0;
      r_vram_sel     <= '0;
      r_drained      <= 1'b0;
    end else begin
      r_vram_we  <= 1'b0;
      r_vram_sel <= '0;
      r_drained  <= 1'b0;
      if (w_pop) begin
        {r_vram_address, r_vram_data, r_vram_sel} <= r_mem[r_rd_ptr[AW-1:0]];
        r_vram_we <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_writable && !w_empty) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!i_writable) begin
            r_state <= S_IDLE;
          end else if (w_empty || (w_pop && w_last)) begin
            r_state   <= S_IDLE;
            r_drained <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scenario bench for vram_write_scheduler: expected writes are queued at push
// time and matched against the writes the monitor captures from the GPU port.
module tb_vram_write_scheduler;

  localparam logic [4:0] PMF  = 5'b00001;
  localparam logic [4:0] NTBL = 5'b00100;
  localparam logic [4:0] OBM  = 5'b01000;
  localparam logic [4:0] TXBL = 5'b10000;

  logic        gpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        writable = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic [4:0]  req_sel = '0;
  logic [11:0] vram_address;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic [4:0]  vram_sel;
  logic [4:0]  pending;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic        drained;

  int n_cmp = 0;
  int n_err = 0;

  logic [24:0] exp_q [$];
  logic [24:0] obs_q [$];
  int          obs_cyc [$];
  int          obs_rd = 0;
  int          cyc_cnt = 0;
  int          drained_cnt = 0;

  vram_write_scheduler #(.ADDR_WIDTH(12), .DEPTH(16)) dut (
    .gpu_clk        (gpu_clk),
    .rst            (rst),
    .i_writable     (writable),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .i_req_data     (req_data),
    .i_req_sel      (req_sel),
    .o_vram_address (vram_address),
    .o_vram_data    (vram_data),
    .o_vram_we      (vram_we),
    .o_vram_sel     (vram_sel),
    .o_pending      (pending),
    .o_overflow     (overflow),
    .i_clr_overflow (clr_overflow),
    .o_drained      (drained)
  );

  always #5 gpu_clk = ~gpu_clk;

  always begin
    @(posedge gpu_clk);
    cyc_cnt++;
    #1;
    if (vram_we) begin
      obs_q.push_back({vram_address, vram_data, vram_sel});
      obs_cyc.push_back(cyc_cnt);
      $display("[%0d] write addr=%h data=%h sel=%b", cyc_cnt, vram_address, vram_data, vram_sel);
    end
    if (drained) drained_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge gpu_clk);
  endtask

  // Presents one request for one edge; it is expected only if the queue can take it.
  task automatic push_req(input logic [11:0] a, input logic [7:0] d, input logic [4:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_sel   = s;
    if (req_ready) exp_q.push_back({a, d, s});
    $display("push addr=%h data=%h sel=%b ready=%b", a, d, s, req_ready);
    @(negedge gpu_clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    writable = 1'b0;
    req_valid = 1'b0;
    clr_overflow = 1'b0;
    @(negedge gpu_clk);
    rst = 1'b0;
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  task automatic test_reset();
    n_cmp++; if (vram_we !== 1'b0)       begin n_err++; $display("FAIL rst_we: got %b want 0", vram_we); end
    n_cmp++; if (vram_sel !== 5'd0)      begin n_err++; $display("FAIL rst_sel: got %b want 0", vram_sel); end
    n_cmp++; if (vram_address !== 12'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", vram_address); end
    n_cmp++; if (vram_data !== 8'd0)     begin n_err++; $display("FAIL rst_data: got %h want 0", vram_data); end
    n_cmp++; if (pending !== 5'd0)       begin n_err++; $display("FAIL rst_pending: got %0d want 0", pending); end
    n_cmp++; if (overflow !== 1'b0)      begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_cmp++; if (drained !== 1'b0)       begin n_err++; $display("FAIL rst_drained: got %b want 0", drained); end
    n_cmp++; if (req_ready !== 1'b1)     begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_idle_then_drain();
    int d0;
    logic [24:0] e;
    d0 = drained_cnt;
    writable = 1'b0;
    push_req(12'h010, 8'hAA, PMF);
    push_req(12'h011, 8'hBB, NTBL);
    push_req(12'h7FF, 8'hCC, TXBL);
    cycles(3);
    n_cmp++; if (obs_q.size() != obs_rd) begin n_err++; $display("FAIL t1_no_we: got %0d writes want 0", obs_q.size() - obs_rd); end
    n_cmp++; if (pending !== 5'd3) begin n_err++; $display("FAIL t1_pending: got %0d want 3", pending); end
    writable = 1'b1;
    for (int k = 0; k < 20 && obs_q.size() < obs_rd + 3; k++) @(negedge gpu_clk);
    cycles(2);
    writable = 1'b0;
    n_cmp++; if (obs_q.size() != obs_rd + 3) begin n_err++; $display("FAIL t1_count: got %0d want 3", obs_q.size() - obs_rd); end
    if (obs_q.size() >= obs_rd + 3) begin
      n_cmp++;
      if (obs_cyc[obs_rd+2] != obs_cyc[obs_rd] + 2 || obs_cyc[obs_rd+1] != obs_cyc[obs_rd] + 1) begin
        n_err++; $display("FAIL t1_consecutive: cycles %0d %0d %0d", obs_cyc[obs_rd], obs_cyc[obs_rd+1], obs_cyc[obs_rd+2]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_rd >= obs_q.size() || exp_q.size() == 0) begin
        n_err++; $display("FAIL t1_write[%0d]: no write observed", i);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin n_err++; $display("FAIL t1_write[%0d]: got %h want %h", i, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    n_cmp++; if (drained_cnt != d0 + 1) begin n_err++; $display("FAIL t1_drained: got %0d pulses want 1", drained_cnt - d0); end
    n_cmp++; if (pending !== 5'd0) begin n_err++; $display("FAIL t1_pending_end: got %0d want 0", pending); end
  endtask

  task automatic test_fill();
    writable = 1'b0;
    for (int i = 0; i < 16; i++) push_req(12'h100 + 12'(i), 8'h10 + 8'(i), 5'b1 << (i % 5));
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL t2_ready_full: got %b want 0", req_ready); end
    n_cmp++; if (pending !== 5'd16)  begin n_err++; $display("FAIL t2_pending_full: got %0d want 16", pending); end
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL t2_overflow_pre: got %b want 0", overflow); end
    push_req(12'h1FF, 8'hEE, PMF);
    n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL t2_overflow_set: got %b want 1", overflow); end
    n_cmp++; if (pending !== 5'd16)  begin n_err++; $display("FAIL t2_pending_17th: got %0d want 16", pending); end
    clr_overflow = 1'b1;
    @(negedge gpu_clk);
    clr_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL t2_overflow_clr: got %b want 0", overflow); end
    req_valid = 1'b1;
    clr_overflow = 1'b1;
    @(negedge gpu_clk);
    req_valid = 1'b0;
    clr_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL t2_clr_priority: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    int d0;
    logic [24:0] e;
    d0 = drained_cnt;
    writable = 1'b1;
    @(negedge gpu_clk);
    n_cmp++; if (pending !== 5'd16) begin n_err++; $display("FAIL t6_pending_pre: got %0d want 16", pending); end
    req_valid = 1'b1;
    req_addr  = 12'h2AA;
    req_data  = 8'h77;
    req_sel   = OBM;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL t6_ready_pop_edge: got %b want 0", req_ready); end
    @(negedge gpu_clk);
    req_valid = 1'b0;
    writable  = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL t6_ready_after: got %b want 1", req_ready); end
    n_cmp++; if (pending !== 5'd15)  begin n_err++; $display("FAIL t6_pending_after: got %0d want 15", pending); end
    n_cmp++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL t6_overflow: got %b want 1", overflow); end
    writable = 1'b1;
    for (int k = 0; k < 40 && obs_q.size() < obs_rd + 16; k++) @(negedge gpu_clk);
    cycles(2);
    writable = 1'b0;
    n_cmp++; if (obs_q.size() != obs_rd + 16) begin n_err++; $display("FAIL t6_count: got %0d want 16", obs_q.size() - obs_rd); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (obs_rd >= obs_q.size() || exp_q.size() == 0) begin
        n_err++; $display("FAIL t6_write[%0d]: no write observed", i);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin n_err++; $display("FAIL t6_write[%0d]: got %h want %h", i, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    n_cmp++; if (drained_cnt != d0 + 1) begin n_err++; $display("FAIL t6_drained: got %0d pulses want 1", drained_cnt - d0); end
  endtask

  task automatic test_vblank();
    int d0;
    logic [24:0] e;
    d0 = drained_cnt;
    writable = 1'b0;
    for (int i = 0; i < 10; i++) push_req(12'h200 + 12'(i), 8'h40 + 8'(i), NTBL);
    writable = 1'b1;
    cycles(5);
    writable = 1'b0;
    cycles(4);
    n_cmp++; if (obs_q.size() != obs_rd + 4) begin n_err++; $display("FAIL t3_window_writes: got %0d want 4", obs_q.size() - obs_rd); end
    n_cmp++; if (pending !== 5'd6) begin n_err++; $display("FAIL t3_pending: got %0d want 6", pending); end
    n_cmp++; if (drained_cnt != d0) begin n_err++; $display("FAIL t3_no_drained: got %0d pulses want 0", drained_cnt - d0); end
    writable = 1'b1;
    for (int k = 0; k < 30 && obs_q.size() < obs_rd + 10; k++) @(negedge gpu_clk);
    cycles(2);
    writable = 1'b0;
    n_cmp++; if (obs_q.size() != obs_rd + 10) begin n_err++; $display("FAIL t3_total: got %0d want 10", obs_q.size() - obs_rd); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (obs_rd >= obs_q.size() || exp_q.size() == 0) begin
        n_err++; $display("FAIL t3_write[%0d]: no write observed", i);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin n_err++; $display("FAIL t3_write[%0d]: got %h want %h", i, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    n_cmp++; if (drained_cnt != d0 + 1) begin n_err++; $display("FAIL t3_drained_next: got %0d pulses want 1", drained_cnt - d0); end
    n_cmp++; if (pending !== 5'd0) begin n_err++; $display("FAIL t3_pending_end: got %0d want 0", pending); end
  endtask

  task automatic test_back_to_back();
    int d0;
    int c0;
    int gaps;
    logic [24:0] e;
    d0 = drained_cnt;
    writable = 1'b1;
    cycles(2);
    c0 = cyc_cnt;
    for (int i = 0; i < 40; i++) begin
      if (i >= 2) begin
        n_cmp++; if (pending !== 5'd2) begin n_err++; $display("FAIL t4_pending[%0d]: got %0d want 2", i, pending); end
      end
      push_req(12'(i), 8'(i), 5'b1 << (i % 5));
    end
    for (int k = 0; k < 20 && obs_q.size() < obs_rd + 40; k++) @(negedge gpu_clk);
    cycles(2);
    writable = 1'b0;
    n_cmp++; if (obs_q.size() != obs_rd + 40) begin n_err++; $display("FAIL t4_count: got %0d want 40", obs_q.size() - obs_rd); end
    if (obs_q.size() >= obs_rd + 40) begin
      n_cmp++; if (obs_cyc[obs_rd] != c0 + 3) begin n_err++; $display("FAIL t4_latency: first write cycle %0d want %0d", obs_cyc[obs_rd], c0 + 3); end
      gaps = 0;
      for (int i = 1; i < 40; i++) if (obs_cyc[obs_rd+i] != obs_cyc[obs_rd+i-1] + 1) gaps++;
      n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL t4_consecutive: got %0d gaps want 0", gaps); end
    end
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if (obs_rd >= obs_q.size() || exp_q.size() == 0) begin
        n_err++; $display("FAIL t4_write[%0d]: no write observed", i);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e || obs_q[obs_rd][12:5] !== 8'(i)) begin
          n_err++; $display("FAIL t4_write[%0d]: got %h want %h", i, obs_q[obs_rd], e);
        end
        obs_rd++;
      end
    end
    n_cmp++; if (drained_cnt != d0 + 1) begin n_err++; $display("FAIL t4_drained: got %0d pulses want 1", drained_cnt - d0); end
    n_cmp++; if (pending !== 5'd0) begin n_err++; $display("FAIL t4_pending_end: got %0d want 0", pending); end
  endtask

  task automatic test_reset_mid_drain();
    int d0;
    logic [24:0] e;
    d0 = drained_cnt;
    writable = 1'b0;
    for (int i = 0; i < 8; i++) push_req(12'h300 + 12'(i), 8'h80 + 8'(i), OBM);
    writable = 1'b1;
    cycles(3);
    rst = 1'b1;
    @(negedge gpu_clk);
    n_cmp++; if (vram_we !== 1'b0)  begin n_err++; $display("FAIL t5_we_after_rst: got %b want 0", vram_we); end
    n_cmp++; if (pending !== 5'd0) begin n_err++; $display("FAIL t5_pending: got %0d want 0", pending); end
    rst = 1'b0;
    cycles(10);
    writable = 1'b0;
    n_cmp++; if (obs_q.size() != obs_rd + 2) begin n_err++; $display("FAIL t5_writes: got %0d want 2", obs_q.size() - obs_rd); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs_rd >= obs_q.size() || exp_q.size() == 0) begin
        n_err++; $display("FAIL t5_write[%0d]: no write observed", i);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[obs_rd] !== e) begin n_err++; $display("FAIL t5_write[%0d]: got %h want %h", i, obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    n_cmp++; if (drained_cnt != d0) begin n_err++; $display("FAIL t5_no_drained: got %0d pulses want 0", drained_cnt - d0); end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    repeat (3) @(negedge gpu_clk);
    rst = 1'b0;
    test_reset();
    test_idle_then_drain();
    test_fill();
    test_full_pop();
    do_reset();
    test_vblank();
    test_back_to_back();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
